// File: rtl/garbage_queue_if.sv
// Outgoing attack handshake between the garbage queue and the network transmitter.
// The master drives valid and count; the slave (transmitter) drives ready.
interface garbage_queue_if;
    logic       send_valid;
    logic       send_ready;
    logic [9:0] send_count;

    modport master (
        output send_valid,
        output send_count,
        input  send_ready
    );

    modport slave (
        input  send_valid,
        input  send_count,
        output send_ready
    );
endinterface

// File: rtl/garbage_queue.sv
// Garbage queue: turns line-count increases into attacks that first cancel pending
// incoming garbage, forwards the remainder, and inserts pending garbage rows after a lock.
module garbage_queue #(
    parameter int unsigned MAX_PENDING    = 20,
    parameter int unsigned MAX_INSERT     = 8,
    parameter int unsigned PLAYFIELD_COLS = 10
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   game_start,
    input  logic [9:0]             lines_sent,
    input  logic                   falling_piece_lock,
    input  logic                   lines_clear_any,
    input  logic                   garbage_in_valid,
    input  logic [4:0]             garbage_in_count,
    garbage_queue_if.master        send,
    output logic [4:0]             garbage_pending,
    output logic                   insert_busy,
    output logic                   garbage_row_valid,
    output logic [3:0]             garbage_hole_col,
    output logic                   insert_done
);

    localparam logic [4:0]  MAX_PEND_C  = 5'(MAX_PENDING);
    localparam logic [3:0]  MAX_INS_C   = 4'(MAX_INSERT);
    localparam logic [15:0] COLS_C      = 16'(PLAYFIELD_COLS);
    localparam logic [15:0] LFSR_SEED_C = 16'hACE1;
    localparam logic [9:0]  ACCUM_MAX_C = 10'd1023;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_INSERT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [9:0]  prev_sent_r;
    logic [9:0]  accum_r;
    logic [9:0]  accum_s;
    logic [4:0]  pending_r;
    logic [4:0]  pending_s;
    logic [3:0]  batch_rem_r;
    logic [3:0]  batch_rem_s;
    logic [3:0]  hole_r;
    logic [3:0]  hole_s;
    logic        done_r;
    logic        done_s;
    logic [15:0] lfsr_r;

    logic [9:0]  delta_s;
    logic [9:0]  cancellable_s;
    logic [9:0]  cancel_s;
    logic [9:0]  remainder_s;
    logic [4:0]  pend_cancel_s;
    logic [9:0]  accum_base_s;
    logic [10:0] accum_sum_s;
    logic [6:0]  pend_sum_s;
    logic        ins_dec_s;
    logic [15:0] hole_full_s;
    logic        send_valid_s;

    // Fibonacci step for taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic fb;
        fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
        return {cur[14:0], fb};
    endfunction

    function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

    assign send_valid_s = (accum_r != 10'd0);
    assign hole_full_s  = lfsr_r % COLS_C;

    // Attack resolution and send accumulator; committed batch rows are never cancelled.
    always_comb begin
        delta_s       = lines_sent - prev_sent_r;
        cancellable_s = {5'd0, pending_r - {1'b0, batch_rem_r}};
        cancel_s      = min10(delta_s, cancellable_s);
        remainder_s   = delta_s - cancel_s;
        pend_cancel_s = pending_r - cancel_s[4:0];
        if (send_valid_s && send.send_ready) begin
            accum_base_s = 10'd0;
        end else begin
            accum_base_s = accum_r;
        end
        accum_sum_s = {1'b0, accum_base_s} + {1'b0, remainder_s};
        if (accum_sum_s[10]) begin
            accum_s = ACCUM_MAX_C;
        end else begin
            accum_s = accum_sum_s[9:0];
        end
    end

    // Insert FSM next-state: batch is sized from pending after this cycle's cancellation.
    always_comb begin
        state_s     = state_r;
        batch_rem_s = batch_rem_r;
        hole_s      = hole_r;
        done_s      = 1'b0;
        ins_dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (falling_piece_lock && !lines_clear_any && (pend_cancel_s != 5'd0)) begin
                    state_s = ST_INSERT;
                    if (pend_cancel_s > {1'b0, MAX_INS_C}) begin
                        batch_rem_s = MAX_INS_C;
                    end else begin
                        batch_rem_s = pend_cancel_s[3:0];
                    end
                    hole_s = hole_full_s[3:0];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INSERT: begin
                ins_dec_s   = 1'b1;
                batch_rem_s = batch_rem_r - 4'd1;
                if (batch_rem_r == 4'd1) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_INSERT;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                batch_rem_s = 4'd0;
                hole_s      = 4'd0;
            end
        endcase
    end

    // Pending count: cancel, then row decrement, then incoming add, then saturate.
    always_comb begin
        pend_sum_s = {2'b00, pend_cancel_s} - {6'd0, ins_dec_s};
        if (garbage_in_valid) begin
            pend_sum_s = pend_sum_s + {2'b00, garbage_in_count};
        end else begin
            pend_sum_s = pend_sum_s;
        end
        if (pend_sum_s > {2'b00, MAX_PEND_C}) begin
            pending_s = MAX_PEND_C;
        end else begin
            pending_s = pend_sum_s[4:0];
        end
    end

    // FSM state register; game_start outranks every other event.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_r <= ST_IDLE;
        end else if (game_start) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            prev_sent_r <= 10'd0;
            accum_r     <= 10'd0;
            pending_r   <= 5'd0;
            batch_rem_r <= 4'd0;
            hole_r      <= 4'd0;
            done_r      <= 1'b0;
        end else if (game_start) begin
            prev_sent_r <= 10'd0;
            accum_r     <= 10'd0;
            pending_r   <= 5'd0;
            batch_rem_r <= 4'd0;
            hole_r      <= 4'd0;
            done_r      <= 1'b0;
        end else begin
            prev_sent_r <= lines_sent;
            accum_r     <= accum_s;
            pending_r   <= pending_s;
            batch_rem_r <= batch_rem_s;
            hole_r      <= hole_s;
            done_r      <= done_s;
        end
    end

    // Hole LFSR runs freely and is deliberately not reseeded by game_start.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lfsr_r <= LFSR_SEED_C;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign send.send_valid   = send_valid_s;
    assign send.send_count   = accum_r;
    assign garbage_pending   = pending_r;
    assign insert_busy       = (state_r == ST_INSERT);
    assign garbage_row_valid = (state_r == ST_INSERT);
    assign garbage_hole_col  = hole_r;
    assign insert_done       = done_r;

endmodule

// File: tb/tb_garbage_queue.sv
// Scoreboard bench for garbage_queue: a cycle model in plain integers predicts each
// cycle's outputs; a monitor pops and compares them after every clock edge.
module tb_garbage_queue;

    logic       clk;
    logic       rst_l;
    logic       game_start;
    logic [9:0] lines_sent;
    logic       falling_piece_lock;
    logic       lines_clear_any;
    logic       garbage_in_valid;
    logic [4:0] garbage_in_count;
    logic [4:0] garbage_pending;
    logic       insert_busy;
    logic       garbage_row_valid;
    logic [3:0] garbage_hole_col;
    logic       insert_done;

    garbage_queue_if gq_if();

    garbage_queue dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .game_start         (game_start),
        .lines_sent         (lines_sent),
        .falling_piece_lock (falling_piece_lock),
        .lines_clear_any    (lines_clear_any),
        .garbage_in_valid   (garbage_in_valid),
        .garbage_in_count   (garbage_in_count),
        .send               (gq_if),
        .garbage_pending    (garbage_pending),
        .insert_busy        (insert_busy),
        .garbage_row_valid  (garbage_row_valid),
        .garbage_hole_col   (garbage_hole_col),
        .insert_done        (insert_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit sv;
        int sc;
        int pend;
        bit busy;
        int hole;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference state
    int m_prev, m_accum, m_pend, m_batch, m_hole, m_lfsr;
    bit m_insert, m_done;
    int cur_ls;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 32'hFFFF;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_accum = 0; m_pend = 0; m_batch = 0; m_hole = 0;
        m_insert = 0; m_done = 0; m_lfsr = 32'hACE1;
    endtask

    // Apply one cycle of inputs, predict the post-edge outputs, advance to next negedge.
    task automatic step(input bit gs, input int ls, input bit lock, input bit clr,
                        input bit gv, input int gc, input bit rdy);
        int delta, cancel, pend_after, newacc, rows, room;
        exp_t e;
        game_start         = gs;
        lines_sent         = 10'(ls);
        falling_piece_lock = lock;
        lines_clear_any    = clr;
        garbage_in_valid   = gv;
        garbage_in_count   = 5'(gc);
        gq_if.send_ready   = rdy;
        cur_ls             = ls & 1023;
        if (gs) begin
            m_prev = 0; m_accum = 0; m_pend = 0; m_batch = 0;
            m_hole = 0; m_insert = 0; m_done = 0;
        end else begin
            delta      = (ls - m_prev) & 1023;
            room       = m_pend - m_batch;
            cancel     = (delta < room) ? delta : room;
            pend_after = m_pend - cancel;
            newacc     = (((m_accum != 0) && rdy) ? 0 : m_accum) + delta - cancel;
            if (newacc > 1023) newacc = 1023;
            rows   = m_insert ? 1 : 0;
            m_done = m_insert && (m_batch == 1);
            if (m_insert) begin
                m_batch--;
                if (m_batch == 0) m_insert = 0;
            end else if (lock && !clr && pend_after > 0) begin
                m_batch  = (pend_after > 8) ? 8 : pend_after;
                m_hole   = m_lfsr % 10;
                m_insert = 1;
            end
            m_pend = pend_after - rows + (gv ? gc : 0);
            if (m_pend > 20) m_pend = 20;
            m_accum = newacc;
            m_prev  = ls & 1023;
        end
        m_lfsr = lfsr_next(m_lfsr);
        e.sv = (m_accum != 0); e.sc = m_accum; e.pend = m_pend;
        e.busy = m_insert; e.hole = m_hole; e.done = m_done;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, cur_ls, 1'b0, 1'b0, 1'b0, 0, rdy);
    endtask

    task automatic restart();
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_send_valid"}, int'(gq_if.send_valid), 0);
        check({tag, "_send_count"}, int'(gq_if.send_count), 0);
        check({tag, "_pending"},    int'(garbage_pending), 0);
        check({tag, "_busy"},       int'(insert_busy), 0);
        check({tag, "_row_valid"},  int'(garbage_row_valid), 0);
        check({tag, "_hole"},       int'(garbage_hole_col), 0);
        check({tag, "_done"},       int'(insert_done), 0);
    endtask

    // Monitor: compare DUT outputs with the predicted entry for this edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("send_valid", int'(gq_if.send_valid), int'(e.sv));
            check("send_count", int'(gq_if.send_count), e.sc);
            check("pending",    int'(garbage_pending), e.pend);
            check("insert_busy", int'(insert_busy), int'(e.busy));
            check("row_valid",  int'(garbage_row_valid), int'(e.busy));
            check("insert_done", int'(insert_done), int'(e.done));
            if (e.busy) check("hole_col", int'(garbage_hole_col), e.hole);
        end
    end

    initial begin
        rst_l = 1'b0; game_start = 1'b0; lines_sent = 10'd0;
        falling_piece_lock = 1'b0; lines_clear_any = 1'b0;
        garbage_in_valid = 1'b0; garbage_in_count = 5'd0; gq_if.send_ready = 1'b0;
        cur_ls = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_l = 1'b1;

        // pure send with ready held low then released
        step(1'b0, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // cancellation against pending garbage
        restart();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 6, 1'b0);
        step(1'b0, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 7, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle(2, 1'b1);

        // insertion: 8-row batch then 3-row batch
        restart();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 11, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(10, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(5, 1'b0);

        // saturation and lock with a line clear
        restart();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 15, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 15, 1'b0);
        step(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        idle(3, 1'b0);

        // simultaneous incoming and attack; attack during INSERT is not cancellable
        restart();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        step(1'b0, 3, 1'b0, 1'b0, 1'b1, 5, 1'b0);
        idle(2, 1'b1);
        restart();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle(6, 1'b0);

        // game_start on the third INSERT cycle
        restart();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 11, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(2, 1'b0);
        restart();
        idle(2, 1'b0);

        // async reset mid-INSERT with an attack outstanding
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 10, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("pre_reset_send_valid", int'(gq_if.send_valid), 1);
        check("pre_reset_busy", int'(insert_busy), 1);
        #1;
        rst_l = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        cur_ls = 0;
        lines_sent = 10'd0;
        @(negedge clk);
        rst_l = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit gs, lock, clr, gv, rdy;
            int ls, gc;
            gs   = ($urandom_range(0, 299) == 0);
            lock = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 2) == 0);
            gv   = ($urandom_range(0, 5) == 0);
            gc   = $urandom_range(0, 31);
            rdy  = ($urandom_range(0, 1) == 1);
            ls   = cur_ls;
            if ($urandom_range(0, 4) == 0) ls = (cur_ls + $urandom_range(1, 4)) & 1023;
            if (gs) ls = 0;
            step(gs, ls, lock, clr, gv, gc, rdy);
        end

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) check("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/garbage_queue.md
Name: garbage_queue

Overview:
- Sits directly downstream of the lines/attack accounting block.
- Consumes its cumulative `lines_sent` count and converts each increase into an attack event.
- Each attack first cancels pending incoming garbage; any remainder is forwarded to the network transmitter through a valid/ready handshake.
- Incoming garbage from the opponent accumulates in a saturating pending counter. After a lock with no line clear, pending garbage is inserted into the playfield one row per cycle, and the pending count also drives the garbage loading bar.

Parameters:
- `MAX_PENDING`, 20: saturation ceiling of the pending incoming-garbage counter.
- `MAX_INSERT`, 8: maximum garbage rows inserted per lock event.
- `PLAYFIELD_COLS`, 10: number of columns; the hole column lies in 0..PLAYFIELD_COLS-1.

Ports:
- `clk` input 1: system clock.
- `rst_l` input 1: asynchronous active-low reset.
- `game_start` input 1: synchronous clear of all state. Same cycle upstream clears `lines_sent`.
- `lines_sent` input 10: cumulative lines sent this game, from the lines/attack accounting block.
- `falling_piece_lock` input 1: single-cycle pulse when the active piece locks.
- `lines_clear_any` input 1: at least one full row on the lock cycle.
- `garbage_in_valid` input 1: incoming garbage packet strobe; always accepted.
- `garbage_in_count` input 5: rows in the incoming packet.
- `send_valid` output 1: outgoing attack available.
- `send_ready` input 1: transmitter accepts the attack.
- `send_count` output 10: rows to send to the opponent.
- `garbage_pending` output 5: pending incoming rows, for the loading bar.
- `insert_busy` output 1: high while in INSERT; gameplay must hold the next spawn.
- `garbage_row_valid` output 1: insert one garbage row this cycle.
- `garbage_hole_col` output 4: hole column of the inserted row.
- `insert_done` output 1: single-cycle pulse after the last row of a batch.

Behaviour:
- Reset (`rst_l` low, async): all outputs 0, FSM = IDLE, `prev_sent` = 0, `accum` = 0, pending = 0. The hole LFSR is set to a nonzero seed (16'hACE1).
- `game_start`: same clear at the clock edge, with priority over every other event in that cycle, including mid-INSERT. The LFSR is not reseeded.
- Attack detection: `delta` = `lines_sent` − `prev_sent` (10-bit). `prev_sent` <= `lines_sent` every cycle.
- Attack resolution, applied when `delta` != 0:
  - `cancellable` = pending − `batch_rem` (rows already committed to a batch cannot be cancelled).
  - `cancel` = min(`delta`, `cancellable`).
  - pending −= `cancel`.
  - `accum` += `delta` − `cancel`.
- Incoming garbage: when `garbage_in_valid`, pending += `garbage_in_count`. This is applied after cancellation in the same cycle, then saturates at `MAX_PENDING`.
- Same-cycle ordering for pending: cancel, then insert decrement, then incoming add, then saturate.
- Send handshake:
  - `send_valid` = (`accum` != 0); `send_count` = `accum`.
  - On `send_valid` && `send_ready`: `accum` <= new `delta` remainder of that cycle (0 if none). The accepted value is never lost or double-counted.
  - `send_count` is stable while `send_valid` is high and ready is low, except that it grows by new attacks.
  - `accum` saturates at 1023.
- FSM IDLE:
  - On `falling_piece_lock` && !`lines_clear_any` && pending != 0: latch `batch_rem` = min(pending, `MAX_INSERT`), latch hole = LFSR[15:0] mod `PLAYFIELD_COLS`, go to INSERT.
  - A lock with a line clear, or with pending == 0, leaves the FSM in IDLE.
- FSM INSERT:
  - `insert_busy` = 1 and `garbage_row_valid` = 1 every cycle.
  - `garbage_hole_col` holds the latched hole for the whole batch.
  - Each cycle: pending −= 1, `batch_rem` −= 1.
  - When `batch_rem` == 1 this cycle: next state IDLE and `insert_done` pulses on the following cycle.
  - INSERT lasts exactly `batch_rem` cycles.
  - `falling_piece_lock` during INSERT is ignored.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
- `garbage_pending` is the registered pending value and is never greater than `MAX_PENDING`.

Test Plan:
- Pure send: pending = 0; `lines_sent` 0→4 → next cycle `send_valid` = 1, `send_count` = 4. Hold `send_ready` = 0 for 3 cycles, then 1 → `send_count` stays 4, then `send_valid` drops.
- Cancellation: inject `garbage_in_count` = 6; `lines_sent` 0→4 → pending = 2, `send_valid` stays 0. Then `lines_sent` 4→7 → pending = 0, `send_count` = 1.
- Insertion: pending = 11; lock with `lines_clear_any` = 0 → 8 consecutive `garbage_row_valid` cycles with a constant hole in 0..9, `insert_done` 1 cycle later, pending = 3. A second lock → 3 rows.
- Saturation: inject 15 then 15 → pending = 20. Lock with `lines_clear_any` = 1 → no insertion, pending stays 20.
- Simultaneous events: in one cycle, `garbage_in_count` = 5 with `delta` = 3 against pending = 2 → pending = 5 (2−2+5), `accum` += 1. During INSERT with `batch_rem` = 4 and pending = 4, an attack of 2 → `cancel` = 0, `accum` = 2.
- Reset/game_start mid-operation: assert `game_start` in the 3rd INSERT cycle → next cycle all outputs 0, FSM IDLE. Async `rst_l` low mid-INSERT with `send_valid` = 1 → outputs 0 without waiting for a clock edge.
